list_sum_datapath: RTL and testbench

Datapath for the linked-list summation engine. It holds the list memory, the running-sum register and the next-pointer register, and raises `next_zero` when the list ends. It sits directly downstream of the list-sum control FSM: it takes that FSM's `ld_sum`/`ld_next`/`sum_sel`/`next_sel`/`a_sel`/`done` and returns `next_zero`. It also gives the host a preload write port and a result interface.

---
 rtl/list_sum_datapath.sv | 106 ++++++++++
 tb/tb_list_sum_datapath.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/list_sum_datapath.sv
// list_sum_datapath: datapath of the linked-list summation engine.
// Holds the list memory, the running-sum and next-pointer registers, and a
// result capture stage. The sequencing of ld_sum/ld_next/sel lines is left
// entirely to the external list-sum controller.
// Node layout: mem[p] = value, mem[p+1] = link; a link of 0 terminates the list.
module list_sum_datapath #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] head,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          ld_sum,
    input  logic          ld_next,
    input  logic          sum_sel,
    input  logic          next_sel,
    input  logic          a_sel,
    input  logic          done,
    output logic          next_zero,
    output logic [DW-1:0] sum,
    output logic [DW-1:0] result,
    output logic          result_valid,
    output logic          overflow,
    output logic [AW-1:0] nodes
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] next_ptr;
    logic [AW-1:0] addr;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] rd_link;
    logic [DW:0]   sum_add;
    logic          start_q;
    logic          done_q;

    // Read address: data word at next, link word one above it (wraps).
    assign addr    = a_sel ? next_ptr : next_ptr + AW'(1);
    assign rd_data = mem[addr];
    assign rd_link = AW'(rd_data);
    assign sum_add = {1'b0, sum} + {1'b0, rd_data};
    assign next_zero = (next_ptr == '0);

    // Host preload port; locked out while a run is active. Memory is not reset.
    always_ff @(posedge clk) begin
        if (!rst && we && !start) begin
            mem[waddr] <= wdata;
        end
    end

    // Sum / next / overflow / node-count registers: reinitialised every idle
    // cycle, loaded under controller strobes while running.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum      <= '0;
            next_ptr <= '0;
            overflow <= 1'b0;
            nodes    <= '0;
        end else if (!start) begin
            sum      <= '0;
            next_ptr <= head;
            overflow <= 1'b0;
            nodes    <= '0;
        end else begin
            if (ld_sum) begin
                sum <= sum_sel ? sum_add[DW-1:0] : '0;
                if (sum_sel && sum_add[DW]) begin
                    overflow <= 1'b1;
                end
                if (nodes != '1) begin
                    nodes <= nodes + AW'(1);
                end
            end
            if (ld_next) begin
                next_ptr <= next_sel ? rd_link : head;
            end
        end
    end

    // Result capture on the first done cycle of a run; a new run (start
    // rising) invalidates the previous result but leaves its value in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q      <= 1'b0;
            done_q       <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            start_q <= start;
            done_q  <= done & start;
            if (start && !start_q) begin
                result_valid <= 1'b0;
            end
            if (done && start && !done_q) begin
                result       <= sum;
                result_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_list_sum_datapath.sv
// Testbench for list_sum_datapath: the bench plays the list-sum controller,
// an abstract list-walk model predicts each run's outcome into a queue, and a
// monitor compares on every rising result_valid.
module tb_list_sum_datapath;

    localparam int DW = 8;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst, start, we, ld_sum, ld_next, sum_sel, next_sel, a_sel, done;
    logic [AW-1:0] head, waddr;
    logic [DW-1:0] wdata;
    logic          next_zero, result_valid, overflow;
    logic [DW-1:0] sum, result;
    logic [AW-1:0] nodes;

    list_sum_datapath #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .head(head),
        .we(we), .waddr(waddr), .wdata(wdata),
        .ld_sum(ld_sum), .ld_next(ld_next), .sum_sel(sum_sel),
        .next_sel(next_sel), .a_sel(a_sel), .done(done),
        .next_zero(next_zero), .sum(sum), .result(result),
        .result_valid(result_valid), .overflow(overflow), .nodes(nodes)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned rsum;
        int unsigned rnodes;
        bit          rovf;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned model_mem [256];
    logic        rv_prev = 1'b0;

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares each freshly presented result against the queue head.
    always @(negedge clk) begin
        if (result_valid && !rv_prev) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got %0d, expected no result", result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_result", result, e.rsum);
                check("sb_nodes", nodes, e.rnodes);
                check("sb_overflow", overflow, e.rovf);
            end
        end
        rv_prev = result_valid;
    end

    task automatic host_write(input int unsigned a, input int unsigned d);
        start = 1'b0;
        we    = 1'b1;
        waddr = AW'(a);
        wdata = DW'(d);
        tick();
        we = 1'b0;
        model_mem[a % 256] = d % 256;
    endtask

    // Walk the list in the model and predict sum, node count and overflow.
    function automatic exp_t predict(input int unsigned h);
        exp_t        e;
        int unsigned p, total, cnt;
        p = h; total = 0; cnt = 0;
        while (p != 0 && cnt < 200) begin
            total += model_mem[p];
            cnt++;
            p = model_mem[(p + 1) % 256];
        end
        e.rsum   = total % 256;
        e.rnodes = cnt;
        e.rovf   = (total > 255);
        return e;
    endfunction

    // Act as the controller: compute node, get next, repeat until next_zero.
    task automatic run_list(input int unsigned h);
        exp_t e;
        int   guard;
        e = predict(h);
        exp_q.push_back(e);
        head  = AW'(h);
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        guard = 0;
        while (!next_zero && guard < 300) begin
            a_sel = 1'b1; sum_sel = 1'b1; ld_sum = 1'b1;
            tick();
            ld_sum = 1'b0; a_sel = 1'b0; next_sel = 1'b1; ld_next = 1'b1;
            tick();
            ld_next = 1'b0;
            guard++;
        end
        if (guard >= 300) begin
            n_cmp++;
            n_bad++;
            $display("FAIL walk_timeout: got %0d steps, expected list end", guard);
        end
        check("run_sum", sum, e.rsum);
        check("run_next_zero", next_zero, 1);
        done = 1'b1;
        tick();
        tick();
        done  = 1'b0;
        start = 1'b0;
        tick();
        check("run_result_held", result, e.rsum);
        check("run_result_valid", result_valid, 1);
    endtask

    initial begin
        int unsigned used [128];
        int unsigned addrs [$];
        int unsigned k, idx, last_result;

        rst = 1'b1; start = 1'b0; we = 1'b0; ld_sum = 1'b0; ld_next = 1'b0;
        sum_sel = 1'b0; next_sel = 1'b0; a_sel = 1'b0; done = 1'b0;
        head = '0; waddr = '0; wdata = '0;
        for (int i = 0; i < 256; i++) model_mem[i] = 0;

        // Memory is not reset, so define every word before it can be read.
        rst = 1'b0;
        for (int i = 0; i < 256; i++) host_write(i, 0);
        rst = 1'b1;
        tick();
        tick();
        check("rst_sum", sum, 0);
        check("rst_next_zero", next_zero, 1);
        check("rst_result", result, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_nodes", nodes, 0);

        rst  = 1'b0;
        head = 8'd4;
        tick();
        check("idle_sum", sum, 0);
        check("idle_next_zero", next_zero, 0);
        check("idle_result_valid", result_valid, 0);

        host_write(4, 5);  host_write(5, 10);
        host_write(10, 7); host_write(11, 0);
        run_list(4);
        check("two_node_nodes", nodes, 0);

        host_write(20, 200); host_write(21, 0);
        run_list(20);

        host_write(30, 200); host_write(31, 40);
        host_write(40, 100); host_write(41, 0);
        run_list(30);

        // Write while running must be dropped.
        start = 1'b1; we = 1'b1; waddr = 8'd4; wdata = 8'd99;
        tick();
        we = 1'b0; start = 1'b0;
        tick();
        run_list(4);
        host_write(4, 99);
        run_list(4);
        host_write(4, 5);
        run_list(4);
        last_result = 12;

        // Abort after the first sum load.
        head = 8'd4;
        tick();
        start = 1'b1; a_sel = 1'b1; sum_sel = 1'b1; ld_sum = 1'b1;
        tick();
        ld_sum = 1'b0;
        check("abort_first_sum", sum, 5);
        check("abort_result_valid_cleared", result_valid, 0);
        start = 1'b0;
        tick();
        check("abort_sum", sum, 0);
        check("abort_nodes", nodes, 0);
        check("abort_next_zero", next_zero, 0);
        check("abort_result_kept", result, last_result);

        // Reset in the middle of a run.
        start = 1'b1; ld_sum = 1'b1;
        tick();
        ld_sum = 1'b0;
        rst = 1'b1;
        tick();
        check("midrst_sum", sum, 0);
        check("midrst_next_zero", next_zero, 1);
        check("midrst_result", result, 0);
        check("midrst_result_valid", result_valid, 0);
        check("midrst_nodes", nodes, 0);
        check("midrst_overflow", overflow, 0);
        rst = 1'b0; start = 1'b0;
        tick();
        run_list(4);

        // Randomised lists on disjoint even-aligned node slots.
        for (int t = 0; t < 15; t++) begin
            for (int i = 0; i < 128; i++) used[i] = 0;
            addrs.delete();
            k = $urandom_range(1, 8);
            while (addrs.size() < k) begin
                idx = $urandom_range(1, 126);
                if (used[idx] == 0) begin
                    used[idx] = 1;
                    addrs.push_back(2 * idx);
                end
            end
            for (int n = 0; n < int'(k); n++) begin
                host_write(addrs[n], $urandom_range(0, 255));
                host_write(addrs[n] + 1, (n + 1 < int'(k)) ? addrs[n + 1] : 0);
            end
            run_list(addrs[0]);
        end

        tick();
        tick();
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
